// File: rtl/skid_pkg.sv
// Shared types and default widths for the two-entry skid buffer.
package skid_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } skid_state_e;

  localparam int DW_DEF = 32;
  localparam int TW_DEF = 10;
  localparam int CW_DEF = 16;

endpackage

// File: rtl/skid_entry_reg.sv
// Enabled payload register with asynchronous active-low clear; one per buffer slot.
module skid_entry_reg #(
  parameter int W = 42
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/skid_stage_2e.sv
// Two-entry valid/ready skid buffer with transfer counter.
// Build option SKID_PARITY_EN adds upstream even-parity checking with a sticky error flag.
module skid_stage_2e
  import skid_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int TW = TW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  input  logic [TW-1:0] in_tag_i,
  input  logic          out_ready_i,
  input  logic          flush_i,
`ifdef SKID_PARITY_EN
  input  logic          parity_i,
  output logic          parity_err_o,
`endif
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  output logic [TW-1:0] out_tag_o,
  output logic [1:0]    occupancy_o,
  output logic [CW-1:0] xfer_count_o
);

  // Handshake: a beat moves when valid and ready are both high at a rising
  // edge; the sender holds data stable while valid is high and ready is low.
  localparam int EW = DW + TW;

  skid_state_e   state_q, state_d;
  logic          in_ready_q, out_valid_q;
  logic [CW-1:0] cnt_q;
  logic [EW-1:0] in_entry, head_d, head_q, tail_q;
  logic          head_en, tail_en, cnt_en;
  logic          accept, deliver;

  assign in_entry = {in_tag_i, in_data_i};
  assign accept   = in_valid_i & in_ready_q;
  assign deliver  = out_valid_q & out_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = in_entry;
    head_en = 1'b0;
    tail_en = 1'b0;
    cnt_en  = 1'b0;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else begin
      cnt_en = deliver;
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_ONE;
            head_en = 1'b1;
          end
        end
        S_ONE: begin
          if (accept && deliver) begin
            head_en = 1'b1;
          end else if (accept) begin
            state_d = S_FULL;
            tail_en = 1'b1;
          end else if (deliver) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (deliver) begin
            state_d = S_ONE;
            head_d  = tail_q;
            head_en = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Ready/valid are flopped from the next state so both leave the block registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != S_FULL);
      out_valid_q <= (state_d != S_EMPTY);
      if (cnt_en) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  skid_entry_reg #(.W(EW)) u_head (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (head_en),
    .d_i    (head_d),
    .q_o    (head_q)
  );

  skid_entry_reg #(.W(EW)) u_tail (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (tail_en),
    .d_i    (in_entry),
    .q_o    (tail_q)
  );

`ifdef SKID_PARITY_EN
  logic par_err_q;

  // Flush wins over a same-cycle bad-parity accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_err_q <= 1'b0;
    end else if (flush_i) begin
      par_err_q <= 1'b0;
    end else if (accept && (^{parity_i, in_tag_i, in_data_i})) begin
      par_err_q <= 1'b1;
    end
  end

  assign parity_err_o = par_err_q;
`endif

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = head_q[DW-1:0];
  assign out_tag_o    = head_q[EW-1:DW];
  assign occupancy_o  = state_q;
  assign xfer_count_o = cnt_q;

endmodule
